multicycle_controller: RTL

//  Multicycle MIPS control FSM. Sequences a shared-memory datapath (one ALU, one memory port) over 3-5 states per instruction.

---
 rtl/mips_ctrl_pkg.sv | 48 ++++
 rtl/multicycle_controller_if.sv | 39 +++
 rtl/mc_alu_decode.sv | 24 ++
 rtl/multicycle_controller.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS controller.
// Covers opcodes, functs, ALU codes, mux selects and the 4-bit state enum.
package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  localparam logic [1:0] SRCB_B       = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    EXECUTE = 4'd6,
    ALUWB   = 4'd7,
    BRANCH  = 4'd8,
    ADDIEX  = 4'd9,
    ADDIWB  = 4'd10,
    JUMP    = 4'd11
  } state_t;

endpackage

// File: rtl/multicycle_controller_if.sv
// Controller <-> datapath bundle: instruction/status inputs and control strobes.
// master = controller side, slave = datapath side.
interface multicycle_controller_if;
  import mips_ctrl_pkg::*;

  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       mem_ready;

  logic       iord;
  logic       mem_write;
  logic       ir_write;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       reg_write;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] pc_src;
  logic       pc_en;
  logic [3:0] alu_control;
  logic       illegal_op;
  logic       instr_done;
  state_t     state;

  modport master (
    input  op, funct, zero, mem_ready,
    output iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
           alu_src_a, alu_src_b, pc_src, pc_en, alu_control,
           illegal_op, instr_done, state
  );

  modport slave (
    output op, funct, zero, mem_ready,
    input  iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
           alu_src_a, alu_src_b, pc_src, pc_en, alu_control,
           illegal_op, instr_done, state
  );
endinterface

// File: rtl/mc_alu_decode.sv
// R-type funct to ALU control decode; unsupported functs fall back to ADD
// with funct_valid low so the FSM can flag them.
module mc_alu_decode
  import mips_ctrl_pkg::*;
(
  input  logic [5:0] funct,
  output logic [3:0] alu_control,
  output logic       funct_valid
);

  always_comb begin
    alu_control = ALU_ADD;
    funct_valid = 1'b1;
    case (funct)
      FN_ADD:  alu_control = ALU_ADD;
      FN_SUB:  alu_control = ALU_SUB;
      FN_AND:  alu_control = ALU_AND;
      FN_OR:   alu_control = ALU_OR;
      FN_SLT:  alu_control = ALU_SLT;
      default: funct_valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle MIPS control FSM with Moore strobes per state.
// Define MC_MEM_WAIT_EN to stall FETCH/MEMRD/MEMWR until mem_ready.
//
// state   | meaning
// FETCH   | read instruction, PC += 4
// DECODE  | branch target into ALUOut, dispatch on op
// MEMADR  | compute load/store address
// MEMRD   | read data memory
// MEMWB   | write MDR to rt
// MEMWR   | write data memory
// EXECUTE | R-type ALU operation
// ALUWB   | write ALUOut to rd
// BRANCH  | compare, take branch on zero
// ADDIEX  | A + signimm
// ADDIWB  | write ALUOut to rt
// JUMP    | load jump target into PC
module multicycle_controller
  import mips_ctrl_pkg::*;
(
  input logic                     clk,
  input logic                     reset,
  multicycle_controller_if.master bus
);

`ifdef MC_MEM_WAIT_EN
  localparam bit WAIT_EN = 1'b1;
`else
  localparam bit WAIT_EN = 1'b0;
`endif

  state_t     state_q, state_d;
  logic       mem_ok;
  logic [3:0] funct_alu;
  logic       funct_valid;
  logic       mem_write_c, ir_write_c, reg_write_c;
  logic       pc_write_c, branch_c, illegal_c, done_c;

  mc_alu_decode u_alu_decode (
    .funct       (bus.funct),
    .alu_control (funct_alu),
    .funct_valid (funct_valid)
  );

  assign mem_ok = WAIT_EN ? bus.mem_ready : 1'b1;

  always_ff @(posedge clk) begin
    if (reset) state_q <= FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d         = state_q;
    bus.iord        = 1'b0;
    bus.reg_dst     = 1'b0;
    bus.mem_to_reg  = 1'b0;
    bus.alu_src_a   = 1'b0;
    bus.alu_src_b   = SRCB_B;
    bus.pc_src      = PCSRC_ALU;
    bus.alu_control = ALU_ADD;
    mem_write_c     = 1'b0;
    ir_write_c      = 1'b0;
    reg_write_c     = 1'b0;
    pc_write_c      = 1'b0;
    branch_c        = 1'b0;
    illegal_c       = 1'b0;
    done_c          = 1'b0;

    case (state_q)
      FETCH: begin
        bus.alu_src_b = SRCB_FOUR;
        ir_write_c    = mem_ok;
        pc_write_c    = mem_ok;
        if (mem_ok) state_d = DECODE;
      end
      DECODE: begin
        bus.alu_src_b = SRCB_IMM_SH2;
        case (bus.op)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_RTYPE:     state_d = EXECUTE;
          OP_BEQ:       state_d = BRANCH;
          OP_ADDI:      state_d = ADDIEX;
          OP_J:         state_d = JUMP;
          default: begin
            illegal_c = 1'b1;
            state_d   = FETCH;
          end
        endcase
      end
      MEMADR: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = SRCB_IMM;
        state_d       = (bus.op == OP_SW) ? MEMWR : MEMRD;
      end
      MEMRD: begin
        bus.iord = 1'b1;
        if (mem_ok) state_d = MEMWB;
      end
      MEMWB: begin
        bus.mem_to_reg = 1'b1;
        reg_write_c    = 1'b1;
        done_c         = 1'b1;
        state_d        = FETCH;
      end
      MEMWR: begin
        // Strobe held through the wait; completion only when memory accepts.
        bus.iord    = 1'b1;
        mem_write_c = 1'b1;
        done_c      = mem_ok;
        if (mem_ok) state_d = FETCH;
      end
      EXECUTE: begin
        bus.alu_src_a   = 1'b1;
        bus.alu_control = funct_alu;
        illegal_c       = ~funct_valid;
        state_d         = funct_valid ? ALUWB : FETCH;
      end
      ALUWB: begin
        bus.reg_dst = 1'b1;
        reg_write_c = 1'b1;
        done_c      = 1'b1;
        state_d     = FETCH;
      end
      BRANCH: begin
        bus.alu_src_a   = 1'b1;
        bus.alu_control = ALU_SUB;
        bus.pc_src      = PCSRC_ALUOUT;
        branch_c        = 1'b1;
        done_c          = 1'b1;
        state_d         = FETCH;
      end
      ADDIEX: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = SRCB_IMM;
        state_d       = ADDIWB;
      end
      ADDIWB: begin
        reg_write_c = 1'b1;
        done_c      = 1'b1;
        state_d     = FETCH;
      end
      JUMP: begin
        bus.pc_src = PCSRC_JUMP;
        pc_write_c = 1'b1;
        done_c     = 1'b1;
        state_d    = FETCH;
      end
      default: state_d = FETCH;
    endcase
  end

  assign bus.state      = state_q;
  assign bus.mem_write  = mem_write_c & ~reset;
  assign bus.ir_write   = ir_write_c  & ~reset;
  assign bus.reg_write  = reg_write_c & ~reset;
  assign bus.pc_en      = (pc_write_c | (branch_c & bus.zero)) & ~reset;
  assign bus.illegal_op = illegal_c   & ~reset;
  assign bus.instr_done = done_c      & ~reset;

endmodule
